// File: rtl/apb2axi_pkg.sv
// Shared parameters, FSM state type and beat-slicing helper for the APB2AXI read-data buffer.
package apb2axi_pkg;

    localparam int unsigned TAG_NUM       = 16;
    localparam int unsigned TAG_W         = $clog2(TAG_NUM);
    localparam int unsigned BEATS_PER_TAG = 16;
    localparam int unsigned AXI_DATA_W    = 64;
    localparam int unsigned APB_DATA_W    = 32;
    localparam int unsigned RATIO         = AXI_DATA_W / APB_DATA_W;
    localparam int unsigned CNT_W         = $clog2(BEATS_PER_TAG) + 1;
    localparam int unsigned WIDX_W        = $clog2(BEATS_PER_TAG * RATIO) + 1;
    localparam int unsigned MEM_DEPTH     = TAG_NUM * BEATS_PER_TAG;
    localparam int unsigned ADDR_W        = $clog2(MEM_DEPTH);

    localparam logic [31:0] RDF_POISON_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_PRESENT
    } rdf_state_e;

    // APB word idx of a beat, least-significant word is idx 0
    function automatic logic [APB_DATA_W-1:0] sub_word(input logic [AXI_DATA_W-1:0] beat,
                                                       input int unsigned idx);
        return APB_DATA_W'(beat >> (idx * APB_DATA_W));
    endfunction

endpackage

// File: rtl/apb2axi_rdf_mem.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
module apb2axi_rdf_mem #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              pclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/apb2axi_rdf.sv
// Per-tag read-data buffer: stores AXI R beats per tag and streams them out as APB words.
// Optional macro APB2AXI_RDF_ERR_POISON_EN replaces error-response beats with DEADBEEF words.
module apb2axi_rdf
    import apb2axi_pkg::*;
(
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  rd_beat_valid,
    output logic                  rd_beat_ready,
    input  logic [TAG_W-1:0]      rd_beat_tag,
    input  logic [AXI_DATA_W-1:0] rd_beat_data,
    input  logic [1:0]            rd_beat_resp,
    input  logic                  rd_beat_last,
    input  logic                  rdf_data_req,
    input  logic [TAG_W-1:0]      rdf_data_req_tag,
    output logic                  rdf_data_valid,
    input  logic                  rdf_data_ready,
    output logic [APB_DATA_W-1:0] rdf_data_out,
    output logic                  rdf_data_last,
    output logic [TAG_NUM-1:0]    tag_done,
    output logic                  ovf_err
);

    logic [1:0]            rst_sync;
    logic                  rst_n;
    rdf_state_e            state, state_n;
    logic [TAG_W-1:0]      cur_tag, cur_tag_n;
    logic [WIDX_W-1:0]     widx, widx_n, widx_inc;
    logic [AXI_DATA_W-1:0] beat_q, beat_n;
    logic [APB_DATA_W-1:0] data_q, data_n;
    logic                  valid_q, valid_n;
    logic [CNT_W-1:0]      wcnt [TAG_NUM];
    logic [CNT_W-1:0]      cur_wcnt;
    logic [TAG_NUM-1:0]    tag_done_q;
    logic                  ovf_q;
    logic                  cur_last, hs, clr, wr_drop, wr_en;
    logic [AXI_DATA_W-1:0] wr_data;
    logic                  mem_re;
    logic [ADDR_W-1:0]     mem_waddr, mem_raddr;
    logic [AXI_DATA_W-1:0] mem_rdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign cur_wcnt = wcnt[cur_tag];
    assign widx_inc = widx + WIDX_W'(1);
    // An empty burst (done, no beats) yields a single last word at index 0
    assign cur_last = tag_done_q[cur_tag] &&
                      ((cur_wcnt == '0) ? (widx == '0)
                                        : (widx == WIDX_W'(cur_wcnt) * WIDX_W'(RATIO) - WIDX_W'(1)));
    assign hs       = (state == S_PRESENT) && valid_q && rdf_data_ready;
    assign clr      = hs && cur_last;

    // The clear of cur_tag on its final handshake wins over a coincident write
    assign wr_drop = (wcnt[rd_beat_tag] == CNT_W'(BEATS_PER_TAG)) || tag_done_q[rd_beat_tag] ||
                     (clr && (rd_beat_tag == cur_tag));
    assign wr_en   = rd_beat_valid && !wr_drop;

`ifdef APB2AXI_RDF_ERR_POISON_EN
    assign wr_data = rd_beat_resp[1] ? {(AXI_DATA_W / 32){RDF_POISON_WORD}} : rd_beat_data;
`else
    logic unused_resp;
    assign unused_resp = ^rd_beat_resp;
    assign wr_data     = rd_beat_data;
`endif

    assign mem_waddr = ADDR_W'(rd_beat_tag) * ADDR_W'(BEATS_PER_TAG) + ADDR_W'(wcnt[rd_beat_tag]);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAG_NUM; i++)
                wcnt[i] <= '0;
            tag_done_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= rd_beat_valid && wr_drop;
            for (int unsigned i = 0; i < TAG_NUM; i++) begin
                if (clr && (TAG_W'(i) == cur_tag)) begin
                    wcnt[i]       <= '0;
                    tag_done_q[i] <= 1'b0;
                end else if (rd_beat_valid && (TAG_W'(i) == rd_beat_tag)) begin
                    if (!wr_drop)
                        wcnt[i] <= wcnt[i] + CNT_W'(1);
                    if (rd_beat_last)
                        tag_done_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        cur_tag_n = cur_tag;
        widx_n    = widx;
        beat_n    = beat_q;
        data_n    = data_q;
        valid_n   = valid_q;
        mem_re    = 1'b0;
        mem_raddr = ADDR_W'(cur_tag) * ADDR_W'(BEATS_PER_TAG) + ADDR_W'(widx / WIDX_W'(RATIO));
        case (state)
            S_IDLE: begin
                if (rdf_data_req) begin
                    cur_tag_n = rdf_data_req_tag;
                    widx_n    = '0;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((widx / WIDX_W'(RATIO)) < WIDX_W'(cur_wcnt)) begin
                    mem_re  = 1'b1;
                    state_n = S_FETCH;
                end else if (tag_done_q[cur_tag] && (cur_wcnt == '0)) begin
                    data_n  = '0;
                    valid_n = 1'b1;
                    state_n = S_PRESENT;
                end
            end
            S_FETCH: begin
                beat_n  = mem_rdata;
                data_n  = sub_word(mem_rdata, 32'(widx % WIDX_W'(RATIO)));
                valid_n = 1'b1;
                state_n = S_PRESENT;
            end
            S_PRESENT: begin
                if (valid_q) begin
                    if (rdf_data_ready) begin
                        valid_n = 1'b0;
                        widx_n  = widx_inc;
                        if (cur_last)
                            state_n = S_IDLE;
                        else if ((widx_inc % WIDX_W'(RATIO)) == '0)
                            state_n = S_WAIT;
                    end
                end else begin
                    // Gap cycle after a handshake: next sub-word of the captured beat
                    data_n  = sub_word(beat_q, 32'(widx % WIDX_W'(RATIO)));
                    valid_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_tag <= '0;
            widx    <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            cur_tag <= cur_tag_n;
            widx    <= widx_n;
            beat_q  <= beat_n;
            data_q  <= data_n;
            valid_q <= valid_n;
        end
    end

    apb2axi_rdf_mem #(
        .DEPTH  (MEM_DEPTH),
        .WIDTH  (AXI_DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .pclk  (pclk),
        .we    (wr_en),
        .waddr (mem_waddr),
        .wdata (wr_data),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign rd_beat_ready  = 1'b1;
    assign rdf_data_valid = valid_q;
    assign rdf_data_out   = data_q;
    assign rdf_data_last  = cur_last;
    assign tag_done       = tag_done_q;
    assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_apb2axi_rdf.sv
// Directed scoreboard bench for apb2axi_rdf: expected words queued per beat, popped on handshake.
module tb_apb2axi_rdf;
    import apb2axi_pkg::*;

    logic                  pclk = 1'b0;
    logic                  presetn = 1'b0;
    logic                  rd_beat_valid = 1'b0;
    logic                  rd_beat_ready;
    logic [TAG_W-1:0]      rd_beat_tag = '0;
    logic [AXI_DATA_W-1:0] rd_beat_data = '0;
    logic [1:0]            rd_beat_resp = '0;
    logic                  rd_beat_last = 1'b0;
    logic                  rdf_data_req = 1'b0;
    logic [TAG_W-1:0]      rdf_data_req_tag = '0;
    logic                  rdf_data_valid;
    logic                  rdf_data_ready = 1'b1;
    logic [APB_DATA_W-1:0] rdf_data_out;
    logic                  rdf_data_last;
    logic [TAG_NUM-1:0]    tag_done;
    logic                  ovf_err;

    always #5 pclk = ~pclk;

    apb2axi_rdf dut (
        .pclk             (pclk),
        .presetn          (presetn),
        .rd_beat_valid    (rd_beat_valid),
        .rd_beat_ready    (rd_beat_ready),
        .rd_beat_tag      (rd_beat_tag),
        .rd_beat_data     (rd_beat_data),
        .rd_beat_resp     (rd_beat_resp),
        .rd_beat_last     (rd_beat_last),
        .rdf_data_req     (rdf_data_req),
        .rdf_data_req_tag (rdf_data_req_tag),
        .rdf_data_valid   (rdf_data_valid),
        .rdf_data_ready   (rdf_data_ready),
        .rdf_data_out     (rdf_data_out),
        .rdf_data_last    (rdf_data_last),
        .tag_done         (tag_done),
        .ovf_err          (ovf_err)
    );

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic                  last;
        logic [APB_DATA_W-1:0] data;
    } exp_t;

    exp_t             sb[$];
    int unsigned      total = 0;
    int unsigned      passed = 0;
    int unsigned      hs_cnt = 0;
    int unsigned      ovf_cnt = 0;
    logic [TAG_W-1:0] rd_tag = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Handshake check at negedge (inputs stable up to the next edge), then advance one cycle
    task automatic tick();
        @(negedge pclk);
        if (rdf_data_valid && rdf_data_ready) begin
            int idx = -1;
            for (int i = 0; i < sb.size(); i++)
                if (idx < 0 && sb[i].tag == rd_tag)
                    idx = i;
            chk("sb_nonempty", 64'(idx >= 0), 64'd1);
            if (idx >= 0) begin
                chk("word", {rdf_data_last, rdf_data_out}, {sb[idx].last, sb[idx].data});
                if (sb[idx].last)
                    chk("done_at_last", 64'(tag_done[rd_tag]), 64'd1);
                sb.delete(idx);
            end
            hs_cnt++;
        end
        @(posedge pclk);
        #1;
        if (ovf_err)
            ovf_cnt++;
    endtask

    task automatic push_beat(input logic [TAG_W-1:0] tag, input logic [AXI_DATA_W-1:0] data,
                             input logic last_word);
        logic [AXI_DATA_W-1:0] d;
        d = data;
        for (int unsigned i = 0; i < RATIO; i++)
            sb.push_back('{tag, last_word && (i == RATIO - 1), APB_DATA_W'(d >> (i * APB_DATA_W))});
    endtask

    task automatic beat(input logic [TAG_W-1:0] tag, input logic [AXI_DATA_W-1:0] data,
                        input logic [1:0] resp, input logic last);
        rd_beat_valid = 1'b1;
        rd_beat_tag   = tag;
        rd_beat_data  = data;
        rd_beat_resp  = resp;
        rd_beat_last  = last;
        tick();
        rd_beat_valid = 1'b0;
        rd_beat_last  = 1'b0;
        rd_beat_resp  = 2'b00;
    endtask

    task automatic start_req(input logic [TAG_W-1:0] tag);
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = tag;
        rd_tag           = tag;
        hs_cnt           = 0;
        tick();
        rdf_data_req = 1'b0;
    endtask

    task automatic wait_words(input int unsigned n, input int unsigned budget);
        int unsigned c = 0;
        while (hs_cnt < n && c < budget) begin
            tick();
            c++;
        end
        chk("words_rcvd", 64'(hs_cnt), 64'(n));
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned c = 0;
        while (!rdf_data_valid && c < budget) begin
            tick();
            c++;
        end
        chk("valid_seen", 64'(rdf_data_valid), 64'd1);
    endtask

    initial begin
        logic [AXI_DATA_W-1:0] d;
        int unsigned           lat;

        // Reset values
        repeat (3) tick();
        chk("rst_ready", 64'(rd_beat_ready), 64'd1);
        chk("rst_valid", 64'(rdf_data_valid), 64'd0);
        chk("rst_last", 64'(rdf_data_last), 64'd0);
        chk("rst_out", 64'(rdf_data_out), 64'd0);
        chk("rst_done", 64'(tag_done), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        presetn = 1'b1;
        repeat (4) tick();

        // Tag 3: four beats, ordered LS word first, last only on word 8
        for (int unsigned k = 0; k < 4; k++) begin
            d = {32'h1111_0000 + k, 32'h2222_0001 + k};
            push_beat(3, d, k == 3);
            beat(3, d, 2'b00, k == 3);
        end
        chk("t3_done_set", 64'(tag_done), 64'h0008);
        start_req(3);
        lat = 1;
        while (!rdf_data_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("t3_latency", 64'(lat), 64'd3);
        wait_words(8, 100);
        chk("t3_done_clr", 64'(tag_done[3]), 64'd0);

        // Tag 5: request before data, cut-through as beats land
        start_req(5);
        repeat (10) tick();
        chk("t5_wait_novalid", 64'(rdf_data_valid), 64'd0);
        for (int unsigned k = 0; k < 2; k++) begin
            d = {32'h5500_0010 + k, 32'h5500_0000 + k};
            push_beat(5, d, k == 1);
            beat(5, d, 2'b00, k == 1);
        end
        wait_words(4, 100);
        chk("t5_done_clr", 64'(tag_done[5]), 64'd0);

        // Tag 1: 17 beats, the 17th (carrying last) dropped
        ovf_cnt = 0;
        for (int unsigned k = 0; k < 17; k++) begin
            d = {32'hA100_0000 + k, 32'hB100_0000 + k};
            if (k < 16)
                push_beat(1, d, k == 15);
            beat(1, d, 2'b00, k == 16);
        end
        repeat (3) tick();
        chk("t1_ovf_once", 64'(ovf_cnt), 64'd1);
        chk("t1_done_set", 64'(tag_done[1]), 64'd1);
        start_req(1);
        wait_words(32, 400);

        // Tag 6: stall ready mid-stream
        for (int unsigned k = 0; k < 2; k++) begin
            d = {32'h6600_0010 + k, 32'h6600_0000 + k};
            push_beat(6, d, k == 1);
            beat(6, d, 2'b00, k == 1);
        end
        start_req(6);
        wait_words(1, 50);
        rdf_data_ready = 1'b0;
        wait_valid(20);
        for (int unsigned s = 0; s < 5; s++) begin
            tick();
            chk("stall_hold", {31'd0, rdf_data_valid, rdf_data_out}, {31'd0, 1'b1, 32'h6600_0010});
        end
        rdf_data_ready = 1'b1;
        wait_words(4, 100);

        // Interleave tag 2 writes/reads with tag 7 writes; req for 7 while busy is ignored
        for (int unsigned k = 0; k < 2; k++) begin
            d = {32'h2200_0010 + k, 32'h2200_0000 + k};
            push_beat(2, d, 1'b0);
            beat(2, d, 2'b00, 1'b0);
        end
        start_req(2);
        d = 64'h7700_0010_7700_0000; push_beat(7, d, 1'b0); beat(7, d, 2'b00, 1'b0);
        d = 64'h2200_0012_2200_0002; push_beat(2, d, 1'b0); beat(2, d, 2'b00, 1'b0);
        d = 64'h7700_0011_7700_0001; push_beat(7, d, 1'b0); beat(7, d, 2'b00, 1'b0);
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = 7;
        d = 64'h2200_0013_2200_0003; push_beat(2, d, 1'b1); beat(2, d, 2'b00, 1'b1);
        rdf_data_req = 1'b0;
        d = 64'h7700_0012_7700_0002; push_beat(7, d, 1'b1); beat(7, d, 2'b00, 1'b1);
        wait_words(8, 200);
        chk("t7_done_set", 64'(tag_done[7]), 64'd1);
        start_req(7);
        wait_words(6, 100);

        // Tag 4: error response on beat 2
        for (int unsigned k = 0; k < 3; k++) begin
            d = {32'h4400_0010 + k, 32'h4400_0000 + k};
`ifdef APB2AXI_RDF_ERR_POISON_EN
            if (k == 1)
                push_beat(4, 64'hDEADBEEF_DEADBEEF, 1'b0);
            else
                push_beat(4, d, k == 2);
`else
            push_beat(4, d, k == 2);
`endif
            beat(4, d, (k == 1) ? 2'b10 : 2'b00, k == 2);
        end
        start_req(4);
        wait_words(6, 100);

        // Tag 10: write coinciding with the final handshake is dropped, region restarts at 0
        d = 64'hA0A0_0001_A0A0_0000;
        push_beat(10, d, 1'b1);
        beat(10, d, 2'b00, 1'b1);
        start_req(10);
        wait_words(1, 50);
        rdf_data_ready = 1'b0;
        wait_valid(20);
        ovf_cnt        = 0;
        rdf_data_ready = 1'b1;
        beat(10, 64'hBAD0_BAD0_BAD0_BAD0, 2'b00, 1'b1);
        tick();
        chk("coll_ovf", 64'(ovf_cnt), 64'd1);
        chk("coll_done_clr", 64'(tag_done[10]), 64'd0);
        d = 64'hC0C0_0001_C0C0_0000;
        push_beat(10, d, 1'b1);
        beat(10, d, 2'b00, 1'b1);
        start_req(10);
        wait_words(2, 50);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Reset mid-stream discards stored data
        for (int unsigned k = 0; k < 2; k++) begin
            d = {32'h8800_0010 + k, 32'h8800_0000 + k};
            beat(8, d, 2'b00, k == 1);
        end
        rd_tag         = 8;
        rdf_data_ready = 1'b0;
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = 8;
        tick();
        rdf_data_req = 1'b0;
        wait_valid(20);
        presetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rdf_data_valid), 64'd0);
        chk("mid_rst_done", 64'(tag_done), 64'd0);
        tick();
        presetn        = 1'b1;
        rdf_data_ready = 1'b1;
        repeat (4) tick();
        chk("post_rst_valid", 64'(rdf_data_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
